// File: rtl/mem_cycle_seq.sv
// Core-memory cycle sequencer: read/strobe/inhibit phase timing per memory cycle,
// with duplex module pairing and error-driven switchover to the good module.
module mem_cycle_seq #(
    parameter int unsigned NMOD      = 2,
    parameter int unsigned CYC       = 7,
    parameter int unsigned RD_PH     = 1,
    parameter int unsigned STB_PH    = 3,
    parameter int unsigned INH_PH    = 4,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    wr,
    input  logic                    halt,
    input  logic                    duplex,
    input  logic [$clog2(NMOD)-1:0] mod,
    input  logic [NMOD-1:0]         perr,
    output logic                    run,
    output logic                    busy,
    output logic [$clog2(CYC)-1:0]  ph,
    output logic                    sync,
    output logic                    rd,
    output logic                    stb,
    output logic                    inh,
    output logic                    wrc,
    output logic [NMOD-1:0]         msel,
    output logic                    done,
    output logic                    err,
    output logic                    swo,
    output logic [NMOD-1:0]         failed
);

    localparam int unsigned MW = $clog2(NMOD);
    localparam int unsigned PW = $clog2(CYC);
    localparam int unsigned CW = $clog2(ERR_LIMIT + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(CYC - 1);
    localparam logic [PW-1:0] PH_RD   = PW'(RD_PH);
    localparam logic [PW-1:0] PH_STB  = PW'(STB_PH);
    localparam logic [PW-1:0] PH_INH  = PW'(INH_PH);
    localparam logic [CW-1:0] CNT_MAX = CW'(ERR_LIMIT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CYCLE  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [NMOD-1:0] msel_q, sel_new;
    logic [NMOD-1:0] failed_q, failed_d;
    logic            dup_q, wrc_q;
    logic            err_q, err_d, swo_q, swo_d;
    logic [CW-1:0]   cnt_q [NMOD];
    logic [CW-1:0]   cnt_d [NMOD];
    logic            last, launch, at_stb, pair_sel;
    logic [MW-1:0]   pa, pb;
    logic [NMOD-1:0] e;

    assign last     = (ph_q == PH_LAST);
    assign launch   = start && !halt && ((state_q == S_IDLE) || ((state_q == S_CYCLE) && last));
    assign at_stb   = (state_q == S_CYCLE) && (ph_q == PH_STB);
    assign pair_sel = dup_q && ($countones(msel_q) == 2);
    assign e        = perr & msel_q;

    always_comb begin : seq_next
        state_d = state_q;
        ph_d    = ph_q;
        case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (start) begin
                    state_d = S_CYCLE;
                    ph_d    = '0;
                end
            end
            S_CYCLE: begin
                if (!last) begin
                    ph_d = ph_q + 1'b1;
                end else begin
                    ph_d = '0;
                    if (launch)    state_d = S_CYCLE;
                    else if (halt) state_d = S_HALTED;
                    else           state_d = S_IDLE;
                end
            end
            S_HALTED: if (!halt) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Module select for a new cycle; a half-failed pair collapses onto the survivor.
    always_comb begin : select
        sel_new = '0;
        pa      = mod & ~MW'(1);
        pb      = mod | MW'(1);
        if (!duplex) begin
            sel_new[mod] = 1'b1;
        end else if (failed_q[pa] && !failed_q[pb]) begin
            sel_new[pb] = 1'b1;
        end else if (!failed_q[pa] && failed_q[pb]) begin
            sel_new[pa] = 1'b1;
        end else begin
            sel_new[pa] = 1'b1;
            sel_new[pb] = 1'b1;
        end
    end

    always_comb begin : error_eval
        failed_d = failed_q;
        err_d    = 1'b0;
        swo_d    = 1'b0;
        for (int i = 0; i < NMOD; i++) cnt_d[i] = cnt_q[i];
        if (at_stb) begin
            if (pair_sel && (e == msel_q)) begin
                err_d = 1'b1;
            end else if (pair_sel) begin
                for (int i = 0; i < NMOD; i++) begin
                    if (msel_q[i] && e[i]) begin
                        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                        if (cnt_d[i] == CNT_MAX) begin
                            failed_d[i] = 1'b1;
                            if (!failed_q[i] && !failed_q[i ^ 1]) swo_d = 1'b1;
                        end
                    end else if (msel_q[i]) begin
                        cnt_d[i] = '0;
                    end
                end
            end else begin
                // Single selected module: no good copy to fall back on.
                err_d = |e;
                for (int i = 0; i < NMOD; i++) begin
                    if (msel_q[i] && !e[i]) cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            msel_q   <= '0;
            dup_q    <= 1'b0;
            wrc_q    <= 1'b0;
            failed_q <= '0;
            err_q    <= 1'b0;
            swo_q    <= 1'b0;
            for (int i = 0; i < NMOD; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            failed_q <= failed_d;
            err_q    <= err_d;
            swo_q    <= swo_d;
            for (int i = 0; i < NMOD; i++) cnt_q[i] <= cnt_d[i];
            if (launch) begin
                msel_q <= sel_new;
                dup_q  <= duplex;
                wrc_q  <= wr;
            end
        end
    end

    assign run    = (state_q != S_HALTED);
    assign busy   = (state_q == S_CYCLE);
    assign ph     = ph_q;
    assign sync   = busy && (ph_q == '0);
    assign rd     = busy && (ph_q >= PH_RD) && (ph_q < PH_INH);
    assign stb    = busy && (ph_q == PH_STB);
    assign inh    = busy && (ph_q >= PH_INH);
    assign done   = busy && last;
    assign wrc    = wrc_q;
    assign msel   = busy ? msel_q : '0;
    assign err    = err_q;
    assign swo    = swo_q;
    assign failed = failed_q;

endmodule

// File: doc/mem_cycle_seq.md
# mem_cycle_seq

Parametrised core-memory cycle sequencer for the LVDC simulation. It generates the read, inhibit and sense-strobe phase timing for one memory cycle at a time across `NMOD` memory modules. In duplex mode it drives a module pair and, on repeated single-sided parity errors, switches over to the good module. It sits between the instruction/timing sequencing logic, which issues `START`, and the memory module models, which consume `MSEL`/`RD`/`INH`/`STB`. It generalises the fixed two-module A/B memory timing with configurable phase positions, module count and error-driven switchover.

## Interface
- `NMOD`, 2: number of memory modules; even, 2..8.
- `CYC`, 7: clocks per memory cycle (phases 0..CYC-1); minimum 4.
- `RD_PH`, 1: first phase of read current; 0 < RD_PH < STB_PH.
- `STB_PH`, 3: sense-strobe phase; STB_PH < INH_PH.
- `INH_PH`, 4: first phase of inhibit/restore; INH_PH ≤ CYC-1.
- `ERR_LIMIT`, 3: consecutive single-sided duplex errors before a module is failed; ≥ 1.
- `CLK` in 1: the single clock; everything is rising-edge.
- `RSTN` in 1: asynchronous, active-low reset.
- `START` in 1: cycle request.
- `WR` in 1: write cycle; restore from the write register instead of the sensed data.
- `HALT` in 1: stop the sequencer after the current cycle.
- `DUPLEX` in 1: duplex mode.
- `MOD` in clog2(NMOD): requested module.
- `PERR` in NMOD: per-module parity error, valid at `STB`.
- `RUN` out 1: sequencer accepting requests.
- `BUSY` out 1: a cycle is in progress.
- `PH` out clog2(CYC): current phase.
- `SYNC` out 1: phase-0 pulse.
- `RD` out 1: read current.
- `STB` out 1: sense strobe.
- `INH` out 1: inhibit/restore current.
- `WRC` out 1: latched `WR`.
- `MSEL` out NMOD: one-hot or pair module select.
- `DONE` out 1: last-phase pulse.
- `ERR` out 1: uncorrectable parity error pulse.
- `SWO` out 1: switchover pulse.
- `FAILED` out NMOD: sticky failed-module mask.

## Operation
- **States.**
  - IDLE: `BUSY`=0, `PH`=0.
  - CYCLE: `PH` counts 0..CYC-1.
  - HALTED: `RUN`=0.
- **IDLE → CYCLE.** Taken on `START`=1 with `RUN`=1. `MOD`, `WR` and `DUPLEX` are latched at this edge.
- **Back-to-back cycles.** `START`=1 at `PH`=CYC-1 with `HALT`=0 begins a new cycle; `PH` wraps to 0 with no idle clock and the inputs are re-latched.
- **Ignored requests.** `START` at any other phase is ignored. There is no queue.
- **End of cycle.** After `PH`=CYC-1 without a new start, the sequencer goes to IDLE. If `HALT`=1 at that edge, it goes to HALTED instead.
- **HALT from IDLE.** `HALT`=1 in IDLE goes to HALTED.
- **HALTED → IDLE.** On `HALT`=0; `RUN` returns to 1.
- **Phase outputs** (all combinational decodes of `PH` while `BUSY`):
  - `RD`=1 for RD_PH ≤ PH < INH_PH.
  - `INH`=1 for PH ≥ INH_PH.
  - `STB`=1 at PH=STB_PH.
  - `SYNC`=1 at PH=0.
  - `DONE`=1 at PH=CYC-1.
- **MSEL in simplex.** One-hot bit `MOD`, held for the whole cycle, including when that module is `FAILED`.
- **MSEL in duplex.** Bits p=`MOD`&~1 and p+1.
  - If exactly one of the pair is `FAILED`, only the other bit is set.
  - If both are `FAILED`, both are set.
- **Error evaluation at STB**, over the selected bits only:
  - Simplex, `PERR`=1: `ERR` pulse.
  - Duplex, both bits in error: `ERR` pulse; error counters unchanged.
  - Duplex, exactly one bit in error: no `ERR`. The bad module's counter increments (saturating at ERR_LIMIT) and the good module's counter clears.
  - Counter reaches ERR_LIMIT: that module's `FAILED` bit sets, with a `SWO` pulse on the same clock. `SWO` never fires if the partner is already `FAILED`.
  - No error on a selected module: its counter clears.
- **Counters.** Width clog2(ERR_LIMIT+1), one per module. `FAILED` clears only on reset.

## Timing
- **Reset values.** All outputs 0 except `RUN`=1. All counters are 0. Reset is asynchronous and takes effect immediately, including mid-cycle; strobes truncate with no `DONE`.
- **Latency.** With `START` sampled at edge t:
  - `SYNC`/`BUSY`/`MSEL` are valid after edge t.
  - `RD` asserts after edge t+RD_PH.
  - `STB` after edge t+STB_PH.
  - `INH` after edge t+INH_PH.
  - `DONE` after edge t+CYC-1.
  - `BUSY` falls after edge t+CYC unless restarted.
- **Pulse widths.** `ERR`/`SWO` are registered: one clock, the clock after `STB`.
- **MSEL change.** After a switchover, `MSEL` changes only at the next cycle's start. `FAILED` updates together with `SWO`.
- **Throughput.** Back-to-back operation gives one cycle per CYC clocks.

## Test plan
- **Single cycle.** Defaults; `START` with `MOD`=1, `DUPLEX`=0 → `MSEL`=2'b10, `RD` high at PH 1–3, `STB` at PH 3, `INH` at PH 4–6, one `DONE`, then IDLE.
- **Back-to-back and ignored start.** `START` held high for 3 cycles → 21 busy clocks, `SYNC` every 7 clocks, no idle gap. A `START` pulse at PH 2 alone is ignored.
- **Duplex switchover.** `DUPLEX`=1, `MOD`=0, `PERR`=2'b01 on 3 consecutive cycles → no `ERR`; `SWO` and `FAILED`=01 after the 3rd; 4th cycle `MSEL`=10.
- **Counter clear and double error.** Duplex `PERR`=01, 01, 00, 01 → counter reaches 2, clears, reaches 1; no `SWO`. A cycle with `PERR`=11 → `ERR` pulse and no counter change.
- **HALT.** `HALT` raised at PH 2 with `START` held → the current cycle completes, `RUN`=0, no new `SYNC`. `HALT` dropped → `RUN`=1 and the cycle starts the next clock.
- **Reset mid-cycle.** `RSTN` low at PH 4 → `INH`, `MSEL`, `BUSY` and `FAILED` go to 0 immediately. After release, `PH`=0 and `RUN`=1.
